// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
//   - state_t   : 4-bit FSM state encoding (FETCH is 0 so reset reads as 0)
//   - OP_*      : opcode field values recognised by the decoder
//   - FN_*      : funct field values for R-type ALU operations
//   - ALU_*     : 3-bit base ALU operation codes (zero-extended when wider)
//   - ctrl_t    : bundle of the single-bit / narrow datapath controls
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Source of the ALU operation code for the current state.
    typedef enum logic [1:0] {
        ALU_SEL_NOP = 2'd0,
        ALU_SEL_ADD = 2'd1,
        ALU_SEL_SUB = 2'd2,
        ALU_SEL_FN  = 2'd3
    } alu_sel_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_re;
        logic       mem_we;
        logic       reg_we;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type ALU control decoder.
//   funct    in  6          : function field of the instruction
//   alu_ctrl out ALUCTRL_W  : ALU operation code; bits above bit 2 are zero
// Unknown funct values decode to ALU_NOP.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_ctrl
);

    logic [2:0] base_code;

    always_comb begin
        base_code = ALU_NOP;
        case (funct)
            FN_ADD:  base_code = ALU_ADD;
            FN_SUB:  base_code = ALU_SUB;
            FN_AND:  base_code = ALU_AND;
            FN_OR:   base_code = ALU_OR;
            FN_XOR:  base_code = ALU_XOR;
            FN_NOR:  base_code = ALU_NOR;
            FN_SLT:  base_code = ALU_SLT;
            default: base_code = ALU_NOP;
        endcase
    end

    assign alu_ctrl[2:0] = base_code;

    genvar gi;
    generate
        for (gi = 3; gi < ALUCTRL_W; gi = gi + 1) begin : g_zext
            assign alu_ctrl[gi] = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath.
//   clk, rst_n              : clock and asynchronous active-low reset
//   op, funct               : opcode and function fields from the IR
//   zero                    : ALU zero flag, used in BRANCH
//   mem_ready               : memory completes the current access this cycle
//   pc_we, ir_we, mem_re,
//   mem_we, reg_we          : write / read strobes
//   iord, reg_dst,
//   mem_to_reg, alu_src_a,
//   alu_src_b, pc_src       : datapath mux selects
//   alu_ctrl                : ALU operation code (ALUCTRL_W bits)
//   illegal                 : high during the DECODE cycle of an unknown opcode
//   state_o                 : current state for debug
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_we,
    output logic                 ir_we,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 reg_we,
    output logic                 iord,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    state_t   state_reg;
    state_t   state_next;
    ctrl_t    ctrl;
    alu_sel_t alu_sel;

    logic [ALUCTRL_W-1:0] fn_alu_ctrl;

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (fn_alu_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        ctrl       = '0;
        alu_sel    = ALU_SEL_NOP;
        state_next = state_reg;

        case (state_reg)
            ST_FETCH: begin
                ctrl.mem_re    = 1'b1;
                ctrl.alu_src_b = 2'b01;
                alu_sel        = ALU_SEL_ADD;
                // IR and PC latch only on the cycle the fetch completes.
                ctrl.ir_we     = mem_ready;
                ctrl.pc_we     = mem_ready;
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // PC + (imm << 2) is computed here so BRANCH can use ALUOut.
                ctrl.alu_src_b = 2'b11;
                alu_sel        = ALU_SEL_ADD;
                case (op)
                    OP_RTYPE:     state_next = ST_EXEC_R;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_ADDI:      state_next = ST_EXEC_I;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_next   = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                alu_sel        = ALU_SEL_ADD;
                state_next     = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrl.mem_re = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) begin
                    state_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_we = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                alu_sel        = ALU_SEL_FN;
                state_next     = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
                state_next   = ST_FETCH;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                alu_sel        = ALU_SEL_ADD;
                state_next     = ST_I_WB;
            end
            ST_I_WB: begin
                ctrl.reg_we = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                alu_sel        = ALU_SEL_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.pc_we     = zero;
                state_next     = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_src = 2'b10;
                ctrl.pc_we  = 1'b1;
                state_next  = ST_FETCH;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // FETCH drives strobes even with no instruction in flight, so the
        // reset level must mask everything, not just the state register.
        if (!rst_n) begin
            ctrl    = '0;
            alu_sel = ALU_SEL_NOP;
        end
    end

    always_comb begin
        alu_ctrl = '0;
        case (alu_sel)
            ALU_SEL_ADD: alu_ctrl = ALUCTRL_W'(ALU_ADD);
            ALU_SEL_SUB: alu_ctrl = ALUCTRL_W'(ALU_SUB);
            ALU_SEL_FN:  alu_ctrl = fn_alu_ctrl;
            default:     alu_ctrl = '0;
        endcase
    end

    assign pc_we      = ctrl.pc_we;
    assign ir_we      = ctrl.ir_we;
    assign mem_re     = ctrl.mem_re;
    assign mem_we     = ctrl.mem_we;
    assign reg_we     = ctrl.reg_we;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign illegal    = ctrl.illegal;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a default-width instance and a
// 5-bit ALU-control instance share all inputs and are checked cycle by cycle.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_we, ir_we, mem_re, mem_we, reg_we, iord, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state_o;

    logic       w_pc_we, w_ir_we, w_mem_re, w_mem_we, w_reg_we, w_iord;
    logic       w_reg_dst, w_mem_to_reg, w_alu_src_a, w_illegal;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [4:0] w_alu_ctrl;
    logic [3:0] w_state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ir_we_cnt  = 0;
    int reg_we_cnt = 0;

    multicycle_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    multicycle_ctrl #(.ALUCTRL_W(5)) u_dut_wide (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (w_pc_we),
        .ir_we      (w_ir_we),
        .mem_re     (w_mem_re),
        .mem_we     (w_mem_we),
        .reg_we     (w_reg_we),
        .iord       (w_iord),
        .reg_dst    (w_reg_dst),
        .mem_to_reg (w_mem_to_reg),
        .alu_src_a  (w_alu_src_a),
        .alu_src_b  (w_alu_src_b),
        .pc_src     (w_pc_src),
        .alu_ctrl   (w_alu_ctrl),
        .illegal    (w_illegal),
        .state_o    (w_state_o)
    );

    // Control bus layout:
    // [16]pc_we [15]ir_we [14]mem_re [13]mem_we [12]reg_we [11]iord
    // [10]reg_dst [9]mem_to_reg [8]alu_src_a [7:6]alu_src_b [5:4]pc_src
    // [3:1]alu_ctrl [0]illegal
    logic [16:0] vec;
    assign vec = {pc_we, ir_we, mem_re, mem_we, reg_we, iord, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ir_we)  ir_we_cnt++;
        if (reg_we) reg_we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic mre,
                                       input logic mwe, input logic rwe, input logic io,
                                       input logic rd, input logic m2r, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] psrc,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, irw, mre, mwe, rwe, io, rd, m2r, asa, asb, psrc, alu, ill};
    endfunction

    // Check one clock cycle at the falling edge, then move just past the
    // next rising edge so the caller can set inputs for the following state.
    task automatic cyc(input string tag, input logic [3:0] es, input logic [16:0] ev,
                       input logic [4:0] ew_alu);
        @(negedge clk);
        $display("[TB] %s state=%0d ctl=0x%05h walu=0x%0h", tag, state_o, vec, w_alu_ctrl);
        check({tag, ".state"}, 32'(state_o), 32'(es));
        check({tag, ".ctl"}, 32'(vec), 32'(ev));
        check({tag, ".wide_alu"}, 32'(w_alu_ctrl), 32'(ew_alu));
        @(posedge clk);
        #1;
    endtask

    localparam logic [16:0] V_FETCH    = 17'b1_1_1_0_0_0_0_0_0_01_00_001_0;
    localparam logic [16:0] V_FETCHW   = 17'b0_0_1_0_0_0_0_0_0_01_00_001_0;
    localparam logic [16:0] V_DECODE   = 17'b0_0_0_0_0_0_0_0_0_11_00_001_0;

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        // Reset holds every output low even though FETCH would strobe.
        @(negedge clk);
        check("reset.state", 32'(state_o), 32'd0);
        check("reset.ctl", 32'(vec), 32'd0);
        check("reset.wide_state", 32'(w_state_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type SUB: 4 cycles
        op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        cyc("sub.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("sub.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("sub.exec",   4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0), 5'b00010);
        cyc("sub.wb",     4'd7, mk(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0), 5'b00000);

        // lw: 2 FETCH waits, 3 MEM_RD waits -> 10 cycles
        ir_we_cnt = 0;
        op = 6'b100011; mem_ready = 1'b0;
        cyc("lw.fetch_w0", 4'd0, V_FETCHW, 5'b00001);
        cyc("lw.fetch_w1", 4'd0, V_FETCHW, 5'b00001);
        mem_ready = 1'b1;
        cyc("lw.fetch",    4'd0, V_FETCH, 5'b00001);
        mem_ready = 1'b0;
        cyc("lw.decode",   4'd1, V_DECODE, 5'b00001);
        cyc("lw.addr",     4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0), 5'b00001);
        cyc("lw.rd_w0",    4'd3, mk(0,0,1,0,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        cyc("lw.rd_w1",    4'd3, mk(0,0,1,0,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        cyc("lw.rd_w2",    4'd3, mk(0,0,1,0,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        mem_ready = 1'b1;
        cyc("lw.rd",       4'd3, mk(0,0,1,0,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        cyc("lw.wb",       4'd4, mk(0,0,0,0,1,0,0,1,0,2'b00,2'b00,3'b000,0), 5'b00000);
        check("lw.ir_we_count", 32'(ir_we_cnt), 32'd1);

        // sw with one write wait
        op = 6'b101011; mem_ready = 1'b1;
        cyc("sw.fetch",   4'd0, V_FETCH, 5'b00001);
        cyc("sw.decode",  4'd1, V_DECODE, 5'b00001);
        cyc("sw.addr",    4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0), 5'b00001);
        mem_ready = 1'b0;
        cyc("sw.wr_w0",   4'd5, mk(0,0,0,1,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        mem_ready = 1'b1;
        cyc("sw.wr",      4'd5, mk(0,0,0,1,0,1,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);

        // beq taken and not taken: 3 cycles each
        op = 6'b000100; zero = 1'b1;
        cyc("beq1.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("beq1.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("beq1.branch", 4'd10, mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b010,0), 5'b00010);
        zero = 1'b0;
        cyc("beq0.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("beq0.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("beq0.branch", 4'd10, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b010,0), 5'b00010);

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        op = 6'b111111;
        cyc("ill.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("ill.decode", 4'd1, mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b001,1), 5'b00001);

        // j: 3 cycles (first FETCH also shows illegal has dropped)
        op = 6'b000010;
        cyc("j.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("j.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("j.jump",   4'd11, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0), 5'b00000);

        // addi: 4 cycles
        op = 6'b001000;
        cyc("addi.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("addi.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("addi.exec",   4'd8, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0), 5'b00001);
        cyc("addi.wb",     4'd9, mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0), 5'b00000);

        // SLT and an unknown funct on both widths
        op = 6'b000000; funct = 6'b101010;
        cyc("slt.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("slt.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("slt.exec",   4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0), 5'b00111);
        cyc("slt.wb",     4'd7, mk(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0), 5'b00000);
        funct = 6'b000001;
        cyc("unk.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("unk.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("unk.exec",   4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0), 5'b00000);
        cyc("unk.wb",     4'd7, mk(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0), 5'b00000);

        // Reset in the middle of a lw read wait
        op = 6'b100011; mem_ready = 1'b1;
        cyc("rst.fetch",  4'd0, V_FETCH, 5'b00001);
        cyc("rst.decode", 4'd1, V_DECODE, 5'b00001);
        cyc("rst.addr",   4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0), 5'b00001);
        mem_ready = 1'b0;
        #2;
        check("rst.in_rd", 32'(state_o), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst.async_state", 32'(state_o), 32'd0);
        check("rst.async_ctl", 32'(vec), 32'd0);
        reg_we_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("rst.after0", 4'd0, V_FETCHW, 5'b00001);
        cyc("rst.after1", 4'd0, V_FETCHW, 5'b00001);
        check("rst.no_reg_we", 32'(reg_we_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
